// File: rtl/dct_pkg.sv
// rtl/dct_pkg.sv - shared constants and helpers for the 8x8 DCT datapath
// Contents: DCT_PTS / DCT_IDX_W / DCT_N constants, packed-row element
// accessors (element k at [(7-k)*N +: N], X0 in the MSBs) and the rounding,
// saturating right-shift used by the optional write-side scaler.
package dct_pkg;

  localparam int DCT_PTS   = 8;
  localparam int DCT_IDX_W = 3;
  localparam int DCT_N     = 16;

  typedef logic [DCT_PTS*DCT_N-1:0] dct_vec_t;

  function automatic logic [DCT_N-1:0] dct_elem_get(input dct_vec_t v, input logic [DCT_IDX_W-1:0] k);
    return v[(DCT_PTS-1-int'(k))*DCT_N +: DCT_N];
  endfunction

  function automatic dct_vec_t dct_elem_set(input dct_vec_t v, input logic [DCT_IDX_W-1:0] k,
                                            input logic [DCT_N-1:0] x);
    dct_vec_t r;
    r = v;
    r[(DCT_PTS-1-int'(k))*DCT_N +: DCT_N] = x;
    return r;
  endfunction

  // sat((x + 2^(shift-1)) >>> shift) into an n-bit signed range. The 64-bit
  // working width is a superset of the n+1 bits the rounding add needs.
  function automatic longint dct_scale(input longint x, input int n, input int shift);
    longint hi;
    longint lo;
    longint r;
    hi = (longint'(1) <<< (n - 1)) - 1;
    lo = -(longint'(1) <<< (n - 1));
    r  = (x + (longint'(1) <<< (shift - 1))) >>> shift;
    if (r > hi) begin
      r = hi;
    end else if (r < lo) begin
      r = lo;
    end
    return r;
  endfunction

endpackage

// File: rtl/dct_tb_bank.sv
// rtl/dct_tb_bank.sv - one 8x8 bank of the transpose buffer
// Ports: clk, reset_ni (sync, active-low, clears every cell), we_i/row_i/
// wr_data_i (packed row write), col_i -> col_data_o (combinational packed
// column read, row 0 in the MSBs).
module dct_tb_bank
  import dct_pkg::*;
#(
  parameter int N = DCT_N
) (
  input  logic                     clk,
  input  logic                     reset_ni,
  input  logic                     we_i,
  input  logic [DCT_IDX_W-1:0]     row_i,
  input  logic [DCT_PTS*N-1:0]     wr_data_i,
  input  logic [DCT_IDX_W-1:0]     col_i,
  output logic [DCT_PTS*N-1:0]     col_data_o
);

  logic [N-1:0] mem_q [DCT_PTS][DCT_PTS];

  always_ff @(posedge clk) begin
    if (!reset_ni) begin
      for (int r = 0; r < DCT_PTS; r++) begin
        for (int c = 0; c < DCT_PTS; c++) begin
          mem_q[r][c] <= '0;
        end
      end
    end else if (we_i) begin
      for (int c = 0; c < DCT_PTS; c++) begin
        mem_q[row_i][c] <= wr_data_i[(DCT_PTS-1-c)*N +: N];
      end
    end
  end

  always_comb begin
    col_data_o = '0;
    for (int k = 0; k < DCT_PTS; k++) begin
      col_data_o[(DCT_PTS-1-k)*N +: N] = mem_q[k][col_i];
    end
  end

endmodule

// File: rtl/dct_transpose_buffer.sv
// rtl/dct_transpose_buffer.sv - ping-pong 8x8 transpose buffer between DCT passes
// Ports: clk, reset (sync, active-low); in_valid/in_ready/in_data (packed
// rows); out_valid/out_ready/out_data (packed columns), out_col, out_last.
// Optional macro DCT_TRANSPOSE_SCALE_EN: rounds and saturates each element
// by >>> SHIFT on write; otherwise elements are stored verbatim.
module dct_transpose_buffer
  import dct_pkg::*;
#(
  parameter int N     = DCT_N,
  parameter int SHIFT = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [DCT_PTS*N-1:0]   in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [DCT_PTS*N-1:0]   out_data,
  output logic [DCT_IDX_W-1:0]   out_col,
  output logic                   out_last
);

  localparam logic [DCT_IDX_W-1:0] LAST_IDX = DCT_IDX_W'(DCT_PTS - 1);

  logic                 wsel_q, wsel_d, rsel_q, rsel_d;
  logic [DCT_IDX_W-1:0] wrow_q, wrow_d, rcol_q, rcol_d;
  logic [1:0]           full_q, full_d;
  logic                 wr_fire, rd_fire;
  logic [DCT_PTS*N-1:0] wr_data;
  logic [DCT_PTS*N-1:0] bank_col [2];

  assign in_ready  = !full_q[wsel_q];
  assign out_valid = full_q[rsel_q];
  assign wr_fire   = in_valid && in_ready;
  assign rd_fire   = out_valid && out_ready;
  assign out_data  = bank_col[rsel_q];
  assign out_col   = rcol_q;
  assign out_last  = out_valid && (rcol_q == LAST_IDX);

`ifdef DCT_TRANSPOSE_SCALE_EN
  always_comb begin
    longint s;
    wr_data = '0;
    for (int k = 0; k < DCT_PTS; k++) begin
      s = dct_scale(longint'(signed'(in_data[(DCT_PTS-1-k)*N +: N])), N, SHIFT);
      wr_data[(DCT_PTS-1-k)*N +: N] = s[N-1:0];
    end
  end
`else
  assign wr_data = in_data;
`endif

  // Write and read fires always target different banks (write needs the
  // bank empty, read needs it full), so both may complete a block together.
  always_comb begin
    wsel_d = wsel_q;
    wrow_d = wrow_q;
    rsel_d = rsel_q;
    rcol_d = rcol_q;
    full_d = full_q;
    if (wr_fire) begin
      if (wrow_q == LAST_IDX) begin
        full_d[wsel_q] = 1'b1;
        wsel_d         = ~wsel_q;
        wrow_d         = '0;
      end else begin
        wrow_d = wrow_q + 1'b1;
      end
    end
    if (rd_fire) begin
      if (rcol_q == LAST_IDX) begin
        full_d[rsel_q] = 1'b0;
        rsel_d         = ~rsel_q;
        rcol_d         = '0;
      end else begin
        rcol_d = rcol_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wsel_q <= 1'b0;
      rsel_q <= 1'b0;
      wrow_q <= '0;
      rcol_q <= '0;
      full_q <= 2'b00;
    end else begin
      wsel_q <= wsel_d;
      rsel_q <= rsel_d;
      wrow_q <= wrow_d;
      rcol_q <= rcol_d;
      full_q <= full_d;
    end
  end

  for (genvar b = 0; b < 2; b++) begin : g_bank
    dct_tb_bank #(.N(N)) u_bank (
      .clk       (clk),
      .reset_ni  (reset),
      .we_i      (wr_fire && (wsel_q == 1'(b))),
      .row_i     (wrow_q),
      .wr_data_i (wr_data),
      .col_i     (rcol_q),
      .col_data_o(bank_col[b])
    );
  end

endmodule
